// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter (uart_tx_dev):
// register word offsets, STATUS/CTRL bit positions and the serialiser states.
package uart_tx_pkg;

    // Word offsets decoded from Addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_CTRL   = 2'd2;
    localparam logic [1:0] REG_DIV    = 2'd3;

    // STATUS bit positions; count occupies three bits starting at ST_CNT_LSB
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE      = 1;
    localparam int CTRL_PAR_ODD = 2;

    // Serialiser states
    //   state    | meaning
    //   S_IDLE   | line high, waiting for EN and a queued byte
    //   S_START  | start bit (low)
    //   S_DATA   | eight data bits, LSB first
    //   S_PARITY | parity bit (only in parity builds)
    //   S_STOP   | stop bit (high)
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte-wide synchronous transmit FIFO. A push while full is accepted only
// when a pop happens on the same edge, so a full FIFO keeps streaming.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [7:0]    din_i,
    output logic [7:0]    dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_i);

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped UART transmitter: register file, transmit FIFO and an 8N1
// serialiser with a programmable bit period. Optional parity support is
// compiled in when UART_TX_PARITY_EN is defined (adds CTRL.PAR_ODD and a
// parity bit between data and stop).
module uart_tx_dev #(
    parameter int               FIFO_DEPTH  = 4,
    parameter int               DIV_W       = 16,
    parameter logic [DIV_W-1:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ,
    output logic        txd
);

    import uart_tx_pkg::*;

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [1:0]       reg_addr;
    logic             data_push;

    logic             en_q, en_d;
    logic             ie_q, ie_d;
    logic             ovf_q, ovf_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             ctrl_par_odd;

    logic [7:0]       fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [3:0]       cnt_ext;

    tx_state_e        state_q;
    logic             txd_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] div_lat_q;
    logic [DIV_W-1:0] cnt_reload;
    logic [7:0]       shreg_q;
    logic [2:0]       bit_q;
    logic             cnt_zero;
    logic             busy;
    logic             frame_start;
    logic             unused_bits;

`ifdef UART_TX_PARITY_EN
    logic             par_odd_q, par_odd_d;
    logic             par_q;
    assign ctrl_par_odd = par_odd_q;
`else
    assign ctrl_par_odd = 1'b0;
`endif

    assign reg_addr    = Addr[3:2];
    assign data_push   = WE && (reg_addr == REG_DATA);
    assign cnt_ext     = 4'(fifo_count);
    assign cnt_zero    = (cnt_q == '0);
    assign cnt_reload  = div_lat_q - DIV_W'(1);
    assign busy        = (state_q != S_IDLE);
    assign txd         = txd_q;
    assign IRQ         = ie_q & en_q & fifo_empty & ~busy;
    assign unused_bits = ^{Addr[31:4], cnt_ext[3]};

    // A new frame starts (and pops) from IDLE, or straight out of an expiring stop bit
    assign frame_start = en_q && !fifo_empty &&
                         ((state_q == S_IDLE) || ((state_q == S_STOP) && cnt_zero));

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (data_push),
        .pop_i   (frame_start),
        .din_i   (Din[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Register-file next state: CPU writes plus sticky overflow on a dropped byte
    always_comb begin
        en_d  = en_q;
        ie_d  = ie_q;
        ovf_d = ovf_q;
        div_d = div_q;
`ifdef UART_TX_PARITY_EN
        par_odd_d = par_odd_q;
`endif
        if (WE) begin
            case (reg_addr)
                REG_STATUS: if (Din[ST_OVF]) ovf_d = 1'b0;
                REG_CTRL: begin
                    en_d = Din[CTRL_EN];
                    ie_d = Din[CTRL_IE];
`ifdef UART_TX_PARITY_EN
                    par_odd_d = Din[CTRL_PAR_ODD];
`endif
                end
                REG_DIV: div_d = (Din[DIV_W-1:0] == '0) ? DIV_W'(1) : Din[DIV_W-1:0];
                default: ;
            endcase
        end
        if (data_push && fifo_full && !frame_start) begin
            ovf_d = 1'b1;
        end
    end

    // Register-file flops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q  <= 1'b0;
            ie_q  <= 1'b0;
            ovf_q <= 1'b0;
            div_q <= DEFAULT_DIV;
`ifdef UART_TX_PARITY_EN
            par_odd_q <= 1'b0;
`endif
        end else begin
            en_q  <= en_d;
            ie_q  <= ie_d;
            ovf_q <= ovf_d;
            div_q <= div_d;
`ifdef UART_TX_PARITY_EN
            par_odd_q <= par_odd_d;
`endif
        end
    end

    // Combinational read mux; DATA reads as zero
    always_comb begin
        Dout = '0;
        case (reg_addr)
            REG_STATUS: begin
                Dout[ST_BUSY]         = busy;
                Dout[ST_FULL]         = fifo_full;
                Dout[ST_EMPTY]        = fifo_empty;
                Dout[ST_OVF]          = ovf_q;
                Dout[ST_CNT_LSB +: 3] = cnt_ext[2:0];
            end
            REG_CTRL: begin
                Dout[CTRL_EN]      = en_q;
                Dout[CTRL_IE]      = ie_q;
                Dout[CTRL_PAR_ODD] = ctrl_par_odd;
            end
            REG_DIV: Dout[DIV_W-1:0] = div_q;
            default: Dout = '0;
        endcase
    end

    // Serialiser: each bit held for div_lat_q cycles via a down-counter to zero
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            txd_q     <= 1'b1;
            cnt_q     <= '0;
            div_lat_q <= DEFAULT_DIV;
            shreg_q   <= '0;
            bit_q     <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else if (frame_start) begin
            // Divisor is captured here so mid-frame DIV writes only affect later frames
            state_q   <= S_START;
            txd_q     <= 1'b0;
            cnt_q     <= div_q - DIV_W'(1);
            div_lat_q <= div_q;
            shreg_q   <= fifo_dout;
            bit_q     <= '0;
`ifdef UART_TX_PARITY_EN
            par_q     <= (^fifo_dout) ^ par_odd_q;
`endif
        end else if (state_q != S_IDLE) begin
            if (!cnt_zero) begin
                cnt_q <= cnt_q - DIV_W'(1);
            end else begin
                cnt_q <= cnt_reload;
                case (state_q)
                    S_START: begin
                        state_q <= S_DATA;
                        txd_q   <= shreg_q[0];
                        shreg_q <= shreg_q >> 1;
                    end
                    S_DATA: begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
                            txd_q   <= par_q;
`else
                            state_q <= S_STOP;
                            txd_q   <= 1'b1;
`endif
                        end else begin
                            bit_q   <= bit_q + 3'd1;
                            txd_q   <= shreg_q[0];
                            shreg_q <= shreg_q >> 1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    S_PARITY: begin
                        state_q <= S_STOP;
                        txd_q   <= 1'b1;
                    end
`endif
                    S_STOP: state_q <= S_IDLE;
                    default: begin
                        state_q <= S_IDLE;
                        txd_q   <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// Self-checking bench for uart_tx_dev. Expected line waveforms are built from
// the frame definition (start, data LSB first, optional parity, stop, each
// bit repeated DIV times); register expectations come from the register map.
module tb_uart_tx_dev;

    import uart_tx_pkg::*;

    localparam int FIFO_DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
    localparam logic [31:0] CTRL_ALL = 32'h7;
`else
    localparam int FB = 10;
    localparam logic [31:0] CTRL_ALL = 32'h3;
`endif

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;
    logic        txd;

    int          n_checks;
    int          n_errors;
    logic [7:0]  exp_q[$];
    int          cur_div;
    logic        ie_exp;
    logic        par_odd_exp;

    uart_tx_dev #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .DIV_W       (16),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ),
        .txd   (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One write cycle; called just after a negedge, returns just after the next one
    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        Addr      = '0;
        Addr[3:2] = a;
        Din       = d;
        WE        = 1'b1;
        @(negedge clk);
        WE        = 1'b0;
        Din       = '0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] v);
        Addr      = '0;
        Addr[3:2] = a;
        #1;
        v = Dout;
    endtask

    // Ideal txd waveform of one frame, one entry per clock cycle
    function automatic logic [63:0] frame_wave(input logic [7:0] b, input int d);
        logic [63:0] w;
        logic        lvl;
        w = '0;
        for (int k = 0; k < FB; k++) begin
            if (k == 0)           lvl = 1'b0;
            else if (k <= 8)      lvl = b[k-1];
            else if (k == FB - 1) lvl = 1'b1;
            else                  lvl = (^b) ^ par_odd_exp;
            for (int j = 0; j < d; j++) w[k*d + j] = lvl;
        end
        return w;
    endfunction

    function automatic logic [63:0] ones(input int len);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < len; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Samples txd/busy/IRQ every cycle for all frames in exp_q (back to back),
    // then checks the line is idle. If now=1 the first frame cycle is the current one.
    task automatic capture(input bit now, input string tag);
        logic [63:0] obs_tx, obs_busy, obs_irq;
        int          len;
        int          nf;
        Addr      = '0;
        Addr[3:2] = REG_STATUS;
        len       = FB * cur_div;
        nf        = exp_q.size();
        for (int f = 0; f < nf; f++) begin
            obs_tx = '0; obs_busy = '0; obs_irq = '0;
            for (int c = 0; c < len; c++) begin
                if (!(now && f == 0 && c == 0)) @(negedge clk);
                #1;
                obs_tx[c]   = txd;
                obs_busy[c] = Dout[ST_BUSY];
                obs_irq[c]  = IRQ;
            end
            chk($sformatf("%s_txd_f%0d", tag, f), obs_tx, frame_wave(exp_q[f], cur_div));
            chk($sformatf("%s_busy_f%0d", tag, f), obs_busy, ones(len));
            chk($sformatf("%s_irq_f%0d", tag, f), obs_irq, 64'h0);
        end
        @(negedge clk);
        #1;
        chk({tag, "_idle_txd"}, {63'h0, txd}, 64'h1);
        chk({tag, "_idle_status"}, {32'h0, Dout}, 64'h4);
        chk({tag, "_idle_irq"}, {63'h0, IRQ}, {63'h0, ie_exp});
        exp_q.delete();
    endtask

    initial begin
        logic [31:0] v;
        logic [63:0] obs, expw;
        logic [7:0]  b0, b1;

        n_checks = 0; n_errors = 0;
        reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0;
        cur_div = 1; ie_exp = 1'b0; par_odd_exp = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Reset state
        reg_read(REG_DATA, v);   chk("rst_data", {32'h0, v}, 64'h0);
        reg_read(REG_STATUS, v); chk("rst_status", {32'h0, v}, 64'h4);
        reg_read(REG_CTRL, v);   chk("rst_ctrl", {32'h0, v}, 64'h0);
        reg_read(REG_DIV, v);    chk("rst_div", {32'h0, v}, 64'd434);
        chk("rst_txd", {63'h0, txd}, 64'h1);
        chk("rst_irq", {63'h0, IRQ}, 64'h0);

        // Register boundaries: DIV of zero stores one, upper DIV/CTRL bits ignored
        reg_write(REG_DIV, 32'h0);        reg_read(REG_DIV, v);  chk("div_zero", {32'h0, v}, 64'h1);
        reg_write(REG_DIV, 32'h0005_0007); reg_read(REG_DIV, v); chk("div_mask", {32'h0, v}, 64'h7);
        reg_write(REG_CTRL, 32'hFFFF_FFFF); reg_read(REG_CTRL, v);
        chk("ctrl_mask", {32'h0, v}, {32'h0, CTRL_ALL});
        chk("irq_idle_en", {63'h0, IRQ}, 64'h1);
        reg_write(REG_CTRL, 32'h0);
        chk("irq_off", {63'h0, IRQ}, 64'h0);

        // Single frame 0xA5, DIV=4, written while enabled and idle
        reg_write(REG_DIV, 32'd4);
        reg_write(REG_CTRL, 32'h1);
        exp_q.push_back(8'hA5); cur_div = 4; ie_exp = 1'b0;
        reg_write(REG_DATA, 32'hA5);
        capture(1'b0, "a5");

        // Overflow: five writes into a four-entry FIFO while disabled
        reg_write(REG_CTRL, 32'h0);
        reg_write(REG_DIV, 32'd1);
        for (int k = 0; k < 5; k++) reg_write(REG_DATA, 32'(8'h11 * (k + 1)));
        reg_read(REG_STATUS, v); chk("ovf_status", {32'h0, v}, 64'h4A);
        reg_write(REG_STATUS, 32'h8);
        reg_read(REG_STATUS, v); chk("ovf_clear", {32'h0, v}, 64'h42);
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h11 * (k + 1)));
        cur_div = 1; ie_exp = 1'b0;
        reg_write(REG_CTRL, 32'h1);
        capture(1'b0, "ovf_drain");

        // Back-to-back frames with interrupt enabled, pushed while running
        reg_write(REG_CTRL, 32'h3);
        chk("b2b_irq_pre", {63'h0, IRQ}, 64'h1);
        reg_write(REG_DIV, 32'd2);
        exp_q.push_back(8'h00); exp_q.push_back(8'hFF); cur_div = 2; ie_exp = 1'b1;
        reg_write(REG_DATA, 32'h00);
        reg_write(REG_DATA, 32'hFF);
        capture(1'b1, "b2b");

        // Clearing EN mid-frame: first frame finishes, second byte stays queued
        reg_write(REG_CTRL, 32'h0);
        b0 = 8'h3C; b1 = 8'hC3;
        reg_write(REG_DATA, {24'h0, b0});
        reg_write(REG_DATA, {24'h0, b1});
        reg_write(REG_CTRL, 32'h1);
        obs = '0;
        fork
            begin
                for (int c = 0; c < 40; c++) begin
                    @(negedge clk);
                    #1;
                    obs[c] = txd;
                end
            end
            begin
                repeat (5) @(negedge clk);
                reg_write(REG_CTRL, 32'h0);
            end
        join
        expw = frame_wave(b0, 2);
        for (int c = FB * 2; c < 40; c++) expw[c] = 1'b1;
        chk("endis_txd", obs, expw);
        reg_read(REG_STATUS, v); chk("endis_status", {32'h0, v}, 64'h10);
        chk("endis_irq", {63'h0, IRQ}, 64'h0);
        exp_q.push_back(b1); cur_div = 2; ie_exp = 1'b0;
        reg_write(REG_CTRL, 32'h1);
        capture(1'b0, "endis_rest");

        // Randomized batches against the frame model
        for (int it = 0; it < 6; it++) begin
            int         n;
            int         d;
            logic [7:0] b;
            d  = int'($urandom_range(1, 5));
            n  = int'($urandom_range(1, FIFO_DEPTH));
            ie_exp = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
            par_odd_exp = 1'($urandom_range(0, 1));
`else
            par_odd_exp = 1'b0;
`endif
            reg_write(REG_CTRL, 32'h0);
            reg_write(REG_DIV, 32'(d));
            for (int k = 0; k < n; k++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                reg_write(REG_DATA, {24'h0, b});
            end
            reg_read(REG_STATUS, v);
            chk($sformatf("rnd%0d_status", it), {32'h0, v},
                64'((n << ST_CNT_LSB) | ((n == FIFO_DEPTH) ? (1 << ST_FULL) : 0)));
            cur_div = d;
            reg_write(REG_CTRL, {29'h0, par_odd_exp, ie_exp, 1'b1});
            capture(1'b0, $sformatf("rnd%0d", it));
        end
        par_odd_exp = 1'b0;

        // Reset mid-frame returns txd high without waiting for a clock edge
        reg_write(REG_CTRL, 32'h0);
        reg_write(REG_DIV, 32'd3);
        reg_write(REG_DATA, 32'h5A);
        reg_write(REG_CTRL, 32'h1);
        repeat (2) @(negedge clk);
        #1;
        chk("rstmid_start", {63'h0, txd}, 64'h0);
        #1;
        reset = 1'b0;
        #1;
        chk("rstmid_txd", {63'h0, txd}, 64'h1);
        @(negedge clk);
        reset = 1'b1;
        reg_read(REG_STATUS, v); chk("rstmid_status", {32'h0, v}, 64'h4);
        reg_read(REG_DIV, v);    chk("rstmid_div", {32'h0, v}, 64'd434);
        reg_read(REG_CTRL, v);   chk("rstmid_ctrl", {32'h0, v}, 64'h0);
        chk("rstmid_irq", {63'h0, IRQ}, 64'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
